// File: rtl/stopwatch_display.sv
// stopwatch_display: renders binary MM:SS from the stopwatch as a 4-digit
// multiplexed common-anode 7-segment display (all outputs active-low).
// Binary to BCD conversion uses a shared iterative double-dabble engine.
// Minutes are converted first, then seconds. The results are committed in a
// single LOAD cycle so the display never shows a half-updated time.
module stopwatch_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       ovf,
  output logic [1:0] dbg_state
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONV_MIN = 2'd1,
    CONV_SEC = 2'd2,
    LOAD     = 2'd3
  } conv_state_t;

  conv_state_t   state;
  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;
  logic [2:0]    bit_cnt;
  logic [7:0]    bcd_acc;     // BCD accumulator of the double-dabble engine
  logic [7:0]    bin_sh;      // binary shift register, MSB shifted out first
  logic [7:0]    min_bcd;     // finished minutes BCD, held until LOAD
  logic [5:0]    cap_sec;     // clamped seconds waiting for their turn
  logic [1:0]    cap_status;
  logic          cap_ovf;
  logic [15:0]   disp_bcd;    // {min tens, min units, sec tens, sec units}
  logic [1:0]    disp_status;
  logic [15:0]   dd_next;
  logic [3:0]    cur_digit;
  logic          scan_wrap;
  logic          capture;
  logic [7:0]    min_clamped;
  logic [5:0]    sec_clamped;

  assign dbg_state   = state;
  assign scan_wrap   = (scan_cnt == SCAN_LAST);
  // One capture per frame, at the end of the minutes-tens slot.
  assign capture     = scan_wrap && (idx == 2'd3) && (state == IDLE);
  assign min_clamped = (minutes > 8'd99) ? 8'd99 : minutes;
  assign sec_clamped = (seconds > 6'd59) ? 6'd59 : seconds;

  // One double-dabble iteration: add 3 to BCD nibbles >= 5, then shift left.
  // Values never exceed 99, so two BCD nibbles are enough and the bit that
  // leaves the top of the accumulator is always zero.
  function automatic logic [15:0] dd_step(input logic [15:0] x);
    logic [7:0] b;
    b = x[15:8];
    if (b[3:0] >= 4'd5) b[3:0] = b[3:0] + 4'd3;
    if (b[7:4] >= 4'd5) b[7:4] = b[7:4] + 4'd3;
    return {b[6:0], x[7:0], 1'b0};
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign dd_next = dd_step({bcd_acc, bin_sh});

  // Scan timebase: each digit stays enabled for SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Converter FSM: capture, convert minutes then seconds, commit together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      bcd_acc     <= 8'd0;
      bin_sh      <= 8'd0;
      min_bcd     <= 8'd0;
      cap_sec     <= 6'd0;
      cap_status  <= 2'd0;
      cap_ovf     <= 1'b0;
      disp_bcd    <= 16'd0;
      disp_status <= 2'd0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            bin_sh     <= min_clamped;
            cap_sec    <= sec_clamped;
            cap_status <= status;
            cap_ovf    <= (minutes > 8'd99);
            bcd_acc    <= 8'd0;
            bit_cnt    <= 3'd0;
            state      <= CONV_MIN;
          end
        end
        CONV_MIN: begin
          if (bit_cnt == 3'd7) begin
            // Last minutes iteration: park the result, reload with seconds.
            min_bcd <= dd_next[15:8];
            bcd_acc <= 8'd0;
            bin_sh  <= {cap_sec, 2'b00};
            bit_cnt <= 3'd0;
            state   <= CONV_SEC;
          end else begin
            {bcd_acc, bin_sh} <= dd_next;
            bit_cnt           <= bit_cnt + 3'd1;
          end
        end
        CONV_SEC: begin
          {bcd_acc, bin_sh} <= dd_next;
          if (bit_cnt == 3'd5) begin
            state <= LOAD;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        LOAD: begin
          disp_bcd    <= {min_bcd, bcd_acc};
          disp_status <= cap_status;
          ovf         <= cap_ovf;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Select the BCD digit belonging to the active scan position.
  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      2'd0: cur_digit = disp_bcd[3:0];
      2'd1: cur_digit = disp_bcd[7:4];
      2'd2: cur_digit = disp_bcd[11:8];
      2'd3: cur_digit = disp_bcd[15:12];
      default: cur_digit = 4'd0;
    endcase
  end

  // Registered display drive; the colon sits on the minutes-units digit and
  // blinks with the seconds-units parity while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= 4'b1111;
      seg  <= 7'h7F;
      dp_n <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= encode(cur_digit);
      if (idx == 2'd2) begin
        dp_n <= (disp_status == 2'b01) ? disp_bcd[0] : 1'b0;
      end else begin
        dp_n <= 1'b1;
      end
    end
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Downstream stage of the stopwatch top. Consumes its binary minutes, seconds and status outputs.
- Drives a 4-digit multiplexed common-anode 7-segment display showing MM:SS.
- Converts binary to BCD with an iterative double-dabble engine, then time-multiplexes the digits.
- Drives a colon decimal point that blinks while the stopwatch is running.

Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays enabled. Legal minimum is 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- minutes  input  8  binary minutes from the stopwatch.
- seconds  input  6  binary seconds from the stopwatch.
- status  input  2  stopwatch state: 00 idle, 01 running, 10 paused, 11 treated as paused.
- an  output  4  digit enables, active-low. an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point (colon), active-low.
- ovf  output  1  high while the displayed minutes are clamped.

Behaviour:
- Reset (sampled on posedge clk while rst=1):
  - an=4'b1111, seg=7'h7F, dp_n=1, ovf=0.
  - Scan counter=0, digit index=0, converter FSM=IDLE, all four display BCD registers=0.
  - Reset mid-conversion aborts the conversion; nothing partial is loaded.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, idx advances 0→1→2→3→0.
  - Outputs are registered: an=~(4'b0001<<idx); seg=encode(digit[idx]).
  - First cycle after reset release: an=4'b1110.
- Digit map:
  - idx0 = seconds units, idx1 = seconds tens.
  - idx2 = minutes units, idx3 = minutes tens.
- Segment encode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Any other code gives 7F (blank).
- Capture:
  - Condition: scan_cnt==SCAN_DIV-1 AND idx==3 AND FSM==IDLE. This is one capture per frame.
  - On capture, latch minutes, seconds and status into internal registers.
  - Input changes after capture are ignored until the next capture.
- Clamp at capture:
  - minutes>99 converts as 99 and sets ovf_pending=1.
  - seconds>59 converts as 59.
- Converter FSM (capture happens in IDLE at cycle T):
  - IDLE → CONV_MIN at T.
  - CONV_MIN: 8 shift/add-3 iterations over the 8-bit clamped minutes, cycles T+1..T+8.
  - CONV_SEC: 6 iterations over the 6-bit clamped seconds, cycles T+9..T+14.
  - LOAD at T+15: the four display BCD registers, ovf and the latched status update together, so there is no tearing. Return to IDLE.
  - New values are visible on seg from T+16, whenever the relevant idx is active.
- Colon:
  - Asserted (dp_n=0) only while idx==2.
  - Latched status==01 (running): dp_n=0 when displayed seconds-units is even, 1 when odd.
  - Otherwise the colon is steady on.
  - dp_n=1 while idx!=2.
- Display persistence: display registers hold their value between LOADs. Before the first LOAD after reset the display shows 00:00.
- Simultaneous events: rst overrides capture, scan and LOAD in the same cycle.

Test Plan (SCAN_DIV=4, frame = 16 cycles):
1. Hold rst=1 for 3 cycles, then release. → During reset an=1111, seg=7F, dp_n=1. First cycle after release: an=1110, seg=40. an steps 1110→1101→1011→0111 every 4 cycles.
2. minutes=12, seconds=34, status=10. → After the first capture+16 cycles, the scan shows idx0=4 (19), idx1=3 (30), idx2=2 (24), idx3=1 (79), ovf=0. dp_n=0 during idx2, 1 elsewhere.
3. status=01 with seconds stepping 33→34. → Colon during idx2 is off (dp_n=1) for the :33 frame and on (dp_n=0) for the :34 frame.
4. minutes=200, seconds=63. → Display 99:59, ovf=1. Then minutes=5, seconds=7 → next LOAD shows 05:07, ovf=0.
5. Change inputs from 10:10 to 20:20 at T+3, mid-conversion. → Display shows 10:10 after that LOAD; 20:20 appears only after the next frame's capture.
6. Assert rst at T+5 with 45:45 in conversion. → The cycle after reset all outputs are at reset values. After release the display shows 00:00 until the next capture completes.
